// File: rtl/piped_boolean_alu_pkg.sv
// piped_boolean_alu_pkg: op codes shared by the pipelined boolean ALU and its testbench
package piped_boolean_alu_pkg;
  typedef logic [2:0] op_t;
  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOT  = 3'd6;
  localparam op_t OP_ADD  = 3'd7;
endpackage

// File: rtl/piped_boolean_alu_if.sv
// piped_boolean_alu_if: operand/result handshake bundle; acc_mode exists only with ALU_ACCUM_EN
interface piped_boolean_alu_if
  import piped_boolean_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  op_t select;
`ifdef ALU_ACCUM_EN
  logic acc_mode;
`endif
  logic out_valid;
  logic out_ready;
  logic [WIDTH:0] out;
  logic zero;
  logic parity;
  logic [CNT_W-1:0] op_count;
`ifdef ALU_ACCUM_EN
  modport master (output in_valid, in1, in2, select, acc_mode, out_ready,
                  input in_ready, out_valid, out, zero, parity, op_count);
  modport slave (input in_valid, in1, in2, select, acc_mode, out_ready,
                 output in_ready, out_valid, out, zero, parity, op_count);
`else
  modport master (output in_valid, in1, in2, select, out_ready,
                  input in_ready, out_valid, out, zero, parity, op_count);
  modport slave (input in_valid, in1, in2, select, out_ready,
                 output in_ready, out_valid, out, zero, parity, op_count);
`endif
endinterface

// File: rtl/piped_boolean_alu_core.sv
// boolean_alu_core: combinational 8-op boolean/add unit; result MSB is the add carry
module boolean_alu_core
  import piped_boolean_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              select,
  output logic [WIDTH:0]   result
);
  always_comb begin
    result = select == OP_AND  ? {1'b0, a & b} :
             select == OP_OR   ? {1'b0, a | b} :
             select == OP_XOR  ? {1'b0, a ^ b} :
             select == OP_NAND ? {1'b0, ~(a & b)} :
             select == OP_NOR  ? {1'b0, ~(a | b)} :
             select == OP_XNOR ? {1'b0, ~(a ^ b)} :
             select == OP_NOT  ? {1'b0, ~a} :
                                 {1'b0, a} + {1'b0, b};
  end
endmodule

// File: rtl/piped_boolean_alu.sv
// piped_boolean_alu: two-stage valid/ready boolean ALU with flags and saturating op counter.
// Define ALU_ACCUM_EN to add the accumulator and acc_mode operand select.
module piped_boolean_alu
  import piped_boolean_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  piped_boolean_alu_if.slave bus
);
  logic s1_valid, s2_ready, s1_load, s2_load;
  logic [WIDTH-1:0] a_q, b_q, op_a;
  op_t sel_q;
  logic [WIDTH:0] res;
  assign s2_ready = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_ready;
  assign s1_load = bus.in_valid && bus.in_ready;
  assign s2_load = s1_valid && s2_ready;
`ifdef ALU_ACCUM_EN
  logic mode_q;
  logic [WIDTH-1:0] acc;
  // accumulator is read in stage 2 so back-to-back accumulate ops see the previous result
  assign op_a = mode_q ? acc : a_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      mode_q <= 1'b0;
    end else begin
      if (s2_load) acc <= res[WIDTH-1:0];
      if (s1_load) mode_q <= bus.acc_mode;
    end
  end
`else
  assign op_a = a_q;
`endif
  boolean_alu_core #(.WIDTH(WIDTH)) core (
    .a(op_a),
    .b(b_q),
    .select(sel_q),
    .result(res)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= OP_AND;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      a_q <= bus.in1;
      b_q <= bus.in2;
      sel_q <= bus.select;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out <= '0;
      bus.zero <= 1'b1;
      bus.parity <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= 1'b1;
      bus.out <= res;
      bus.zero <= res[WIDTH-1:0] == '0;
      bus.parity <= ^res[WIDTH-1:0];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) bus.op_count <= '0;
    else if (bus.out_valid && bus.out_ready && bus.op_count != '1) bus.op_count <= bus.op_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_piped_boolean_alu.sv
// tb_piped_boolean_alu: vector tables, stall/reset sequences and random traffic against a queue model
module tb_piped_boolean_alu;
  import piped_boolean_alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  piped_boolean_alu_if #(.WIDTH(4), .CNT_W(8)) bus ();
  piped_boolean_alu #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  piped_boolean_alu_if #(.WIDTH(4), .CNT_W(2)) bus2 ();
  piped_boolean_alu #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    op_t sel;
    logic acc;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[16];
  int n_tbl;
  int n_chk = 0;
  int n_fail = 0;
  logic [4:0] sb[$];
  logic [3:0] acc_m = '0;
  function automatic logic [4:0] ref_op(logic [3:0] a, logic [3:0] b, op_t s);
    int sum;
    logic [3:0] r;
    sum = int'(a) + int'(b);
    case (s)
      OP_AND: r = a & b;
      OP_OR: r = a | b;
      OP_XOR: r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR: r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOT: r = ~a;
      default: return 5'(sum);
    endcase
    return {1'b0, r};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // called ~1ns after inputs change: scores this cycle's handshakes, then advances one cycle
  task automatic tick();
    logic [4:0] e;
    logic [3:0] a;
    if (rst) begin
      sb.delete();
      acc_m = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_out", 32'(1), 32'(0));
        else begin
          e = sb.pop_front();
          chk("sb_out", 32'(bus.out), 32'(e));
          chk("sb_zero", 32'(bus.zero), 32'(e[3:0] == 4'd0));
          chk("sb_parity", 32'(bus.parity), 32'(^e[3:0]));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        a = bus.in1;
`ifdef ALU_ACCUM_EN
        if (bus.acc_mode) a = acc_m;
`endif
        e = ref_op(a, bus.in2, bus.select);
        acc_m = e[3:0];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(logic v, logic [3:0] a, logic [3:0] b, op_t s, logic m);
    bus.in_valid = v;
    bus.in1 = a;
    bus.in2 = b;
    bus.select = s;
`ifdef ALU_ACCUM_EN
    bus.acc_mode = m;
`else
    if (m) bus.in_valid = v;
`endif
  endtask
  // back-to-back table run: entry i must be on the output exactly two cycles after it was offered
  task automatic run_tbl(string name);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n_tbl + 2; i++) begin
      if (i < n_tbl) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].acc);
      else drive(1'b0, 4'd0, 4'd0, OP_AND, 1'b0);
      #1;
      if (i < n_tbl) chk({name, "_in_ready"}, 32'(bus.in_ready), 32'(1));
      if (i >= 2) begin
        chk({name, "_valid"}, 32'(bus.out_valid), 32'(1));
        chk({name, "_out"}, 32'(bus.out), 32'(tbl[i-2].exp));
        chk({name, "_zero"}, 32'(bus.zero), 32'(tbl[i-2].exp[3:0] == 4'd0));
        chk({name, "_parity"}, 32'(bus.parity), 32'(^tbl[i-2].exp[3:0]));
      end
      tick();
    end
  endtask
  task automatic drain(string name);
    bus.out_ready = 1'b1;
    drive(1'b0, 4'd0, 4'd0, OP_AND, 1'b0);
    for (int w = 0; w < 20 && (sb.size() != 0 || bus.out_valid); w++) begin
      #1;
      tick();
    end
    chk({name, "_empty"}, 32'(sb.size()), 32'(0));
    chk({name, "_idle"}, 32'(bus.out_valid), 32'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end
  initial begin
    logic [4:0] held;
    int idx;
    drive(1'b0, 4'd0, 4'd0, OP_AND, 1'b0);
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.out_ready = 1'b1;
    bus2.in1 = 4'd3;
    bus2.in2 = 4'd5;
    bus2.select = OP_ADD;
`ifdef ALU_ACCUM_EN
    bus2.acc_mode = 1'b0;
`endif
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out", 32'(bus.out), 32'(0));
    chk("rst_zero", 32'(bus.zero), 32'(1));
    chk("rst_parity", 32'(bus.parity), 32'(0));
    chk("rst_op_count", 32'(bus.op_count), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_op_count_w2", 32'(bus2.op_count), 32'(0));
    // stall: out_ready low for 5 cycles while 4 ops are offered
    idx = 0;
    for (int w = 0; w < 40; w++) begin
      bus.out_ready = w >= 5;
      if (idx < 4) drive(1'b1, 4'($urandom), 4'($urandom), op_t'($urandom_range(7)), 1'b0);
      else drive(1'b0, 4'd0, 4'd0, OP_AND, 1'b0);
      #1;
      if (w == 2) begin
        chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
        chk("stall_accepted", 32'(idx), 32'(2));
        held = bus.out;
      end
      if (w == 4) begin
        chk("stall_hold_valid", 32'(bus.out_valid), 32'(1));
        chk("stall_hold_out", 32'(bus.out), 32'(held));
        chk("stall_accepted_late", 32'(idx), 32'(2));
      end
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
      if (idx == 4 && sb.size() == 0 && !bus.out_valid) break;
    end
    chk("stall_all_sent", 32'(idx), 32'(4));
    chk("stall_empty", 32'(sb.size()), 32'(0));
    chk("stall_op_count", 32'(bus.op_count), 32'(4));
    // reset with both stages occupied
    bus.out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      drive(1'b1, 4'd9, 4'd3, OP_ADD, 1'b0);
      #1;
      tick();
    end
    drive(1'b0, 4'd0, 4'd0, OP_AND, 1'b0);
    chk("full_out_valid", 32'(bus.out_valid), 32'(1));
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_out", 32'(bus.out), 32'(0));
    chk("midrst_zero", 32'(bus.zero), 32'(1));
    chk("midrst_op_count", 32'(bus.op_count), 32'(0));
    chk("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    bus.out_ready = 1'b1;
    tick();
    chk("midrst_no_ghost", 32'(bus.out_valid), 32'(0));
    // select sweep with in1=1010, in2=0101
    tbl[0] = '{4'b1010, 4'b0101, OP_AND, 1'b0, 5'b00000};
    tbl[1] = '{4'b1010, 4'b0101, OP_OR, 1'b0, 5'b01111};
    tbl[2] = '{4'b1010, 4'b0101, OP_XOR, 1'b0, 5'b01111};
    tbl[3] = '{4'b1010, 4'b0101, OP_NAND, 1'b0, 5'b01111};
    tbl[4] = '{4'b1010, 4'b0101, OP_NOR, 1'b0, 5'b00000};
    tbl[5] = '{4'b1010, 4'b0101, OP_XNOR, 1'b0, 5'b00000};
    tbl[6] = '{4'b1010, 4'b0101, OP_NOT, 1'b0, 5'b00101};
    tbl[7] = '{4'b1010, 4'b0101, OP_ADD, 1'b0, 5'b01111};
    tbl[8] = '{4'b1111, 4'b0001, OP_ADD, 1'b0, 5'b10000};
    tbl[9] = '{4'b0111, 4'b0001, OP_ADD, 1'b0, 5'b01000};
    n_tbl = 10;
    run_tbl("sweep");
    drain("sweep");
`ifdef ALU_ACCUM_EN
    tbl[0] = '{4'b0001, 4'b0001, OP_ADD, 1'b0, 5'b00010};
    tbl[1] = '{4'b0000, 4'b0011, OP_ADD, 1'b1, 5'b00101};
    tbl[2] = '{4'b1111, 4'b0011, OP_ADD, 1'b1, 5'b01000};
    tbl[3] = '{4'b0110, 4'b0011, OP_ADD, 1'b1, 5'b01011};
    n_tbl = 4;
    run_tbl("accum");
    drain("accum");
`endif
    // random traffic with random backpressure
    for (int w = 0; w < 400; w++) begin
      bus.out_ready = $urandom_range(3) != 0;
      drive($urandom_range(3) != 0, 4'($urandom), 4'($urandom), op_t'($urandom_range(7)), 1'($urandom));
      #1;
      tick();
    end
    drain("random");
    chk("sat_op_count", 32'(bus2.op_count), 32'(3));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
